// File: rtl/dc2_mon_pkg.sv
// Shared definitions for the dc2 switching-activity monitor.
// Holds the monitor FSM state type, default geometry constants and a small
// popcount helper used to feed the total-toggle counter.
package dc2_mon_pkg;

  localparam int DC2_WIDTH = 7;   // dc2 result vector width
  localparam int DC2_CNT_W = 16;  // toggle counter width
  localparam int DC2_WIN_W = 16;  // window length field width
  localparam int IDX_W     = 3;   // read index width
  localparam int TOTAL_IDX = DC2_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIRST,
    ST_COUNT,
    ST_DRAIN
  } mon_state_t;

  // Number of set bits in an 8-bit vector (covers any WIDTH up to 8).
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/dc2_sat_counter.sv
// Saturating unsigned up-counter.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset (clears q)
//   clr         : synchronous clear (window start)
//   inc_en      : apply inc this cycle
//   inc [3:0]   : increment amount
//   q   [W-1:0] : count, clamps at 2^W-1
//   sat_hit     : combinational; this cycle's increment would overflow
module dc2_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc_en,
  input  logic [3:0]   inc,
  output logic [W-1:0] q,
  output logic         sat_hit
);

  // Wide enough that q + inc can never wrap, even when W is small.
  localparam int SW = W + 5;
  localparam logic [SW-1:0] MAXV = {{5{1'b0}}, {W{1'b1}}};

  logic [SW-1:0] sum;
  logic          over;

  assign sum     = SW'(q) + SW'(inc);
  assign over    = sum > MAXV;
  assign sat_hit = inc_en && over;

  always_ff @(posedge clk) begin
    if (!rst_n)      q <= '0;
    else if (clr)    q <= '0;
    else if (inc_en) q <= over ? {W{1'b1}} : sum[W-1:0];
  end

endmodule

// File: rtl/dc2_toggle_monitor.sv
// Switching-activity monitor for the dc2 result vector.
// Counts per-bit and total toggles between successive valid samples over a
// window of win_len samples, then drains WIDTH+1 counts over a valid/ready
// port (entries 0..WIDTH-1 per bit, entry WIDTH = total).
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   start, win_len        : arm request and window length (IDLE only, len != 0)
//   smp_valid, smp_data   : sample stream
//   busy                  : not IDLE
//   rd_valid/rd_ready     : result handshake (DRAIN only)
//   rd_idx/rd_data/rd_last: current result entry
//   sat                   : some counter clamped during this window
module dc2_toggle_monitor
  import dc2_mon_pkg::*;
#(
  parameter int WIDTH = DC2_WIDTH,
  parameter int CNT_W = DC2_CNT_W,
  parameter int WIN_W = DC2_WIN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic             smp_valid,
  input  logic [WIDTH-1:0] smp_data,
  output logic             busy,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_last,
  output logic             sat
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH);

  mon_state_t                    state;
  logic [WIN_W-1:0]              remaining;
  logic [WIDTH-1:0]              prev;
  logic [WIDTH-1:0]              t;
  logic [WIDTH-1:0][CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]              total;
  logic [WIDTH-1:0]              bit_hit;
  logic                          tot_hit;
  logic                          arm;
  logic                          cnt_en;
  logic                          last_smp;

  assign arm      = (state == ST_IDLE) && start && (win_len != '0);
  assign cnt_en   = (state == ST_COUNT) && smp_valid;
  assign last_smp = remaining == WIN_W'(1);
  assign t        = prev ^ smp_data;

  // One saturating counter per monitored bit.
  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_bit
      dc2_sat_counter #(.W(CNT_W)) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (arm),
        .inc_en  (cnt_en),
        .inc     ({3'b000, t[g]}),
        .q       (cnt[g]),
        .sat_hit (bit_hit[g])
      );
    end
  endgenerate

  // Total saturates on its own, independent of the per-bit counters.
  dc2_sat_counter #(.W(CNT_W)) u_total (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (arm),
    .inc_en  (cnt_en),
    .inc     (popcount8(8'(t))),
    .q       (total),
    .sat_hit (tot_hit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      remaining <= '0;
      prev      <= '0;
      rd_idx    <= '0;
      busy      <= 1'b0;
      rd_valid  <= 1'b0;
      sat       <= 1'b0;
    end else begin
      // Hits only occur in COUNT, so this never collides with the clear on arm.
      if (|bit_hit || tot_hit) sat <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (arm) begin
            remaining <= win_len;
            sat       <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_FIRST;
          end
        end
        ST_FIRST, ST_COUNT: begin
          if (smp_valid) begin
            prev      <= smp_data;
            remaining <= remaining - WIN_W'(1);
            if (last_smp) begin
              state    <= ST_DRAIN;
              rd_valid <= 1'b1;
            end else begin
              state <= ST_COUNT;
            end
          end
        end
        ST_DRAIN: begin
          if (rd_ready) begin
            if (rd_idx == LAST_IDX) begin
              state    <= ST_IDLE;
              rd_idx   <= '0;
              busy     <= 1'b0;
              rd_valid <= 1'b0;
            end else begin
              rd_idx <= rd_idx + IDX_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Result mux: any index not matching a bit selects the total.
  always_comb begin
    rd_data = total;
    for (int i = 0; i < WIDTH; i++)
      if (rd_idx == IDX_W'(i)) rd_data = cnt[i];
  end

  assign rd_last = rd_idx == LAST_IDX;

endmodule

// File: tb/tb_dc2_toggle_monitor.sv
// Directed bench for dc2_toggle_monitor. Two instances (16-bit and 4-bit
// counters) share one stimulus stream; a window-level model predicts the
// outputs of both every cycle, and literal expectations pin the results.
module tb_dc2_toggle_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] win_len = '0;
  logic        smp_valid = 1'b0;
  logic [6:0]  smp_data = '0;
  logic        rd_ready = 1'b1;

  logic        a_busy, a_rd_valid, a_rd_last, a_sat;
  logic [2:0]  a_rd_idx;
  logic [15:0] a_rd_data;
  logic        b_busy, b_rd_valid, b_rd_last, b_sat;
  logic [2:0]  b_rd_idx;
  logic [3:0]  b_rd_data;

  always #5 clk = ~clk;

  dc2_toggle_monitor #(.WIDTH(7), .CNT_W(16), .WIN_W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len),
    .smp_valid(smp_valid), .smp_data(smp_data), .busy(a_busy),
    .rd_valid(a_rd_valid), .rd_ready(rd_ready), .rd_idx(a_rd_idx),
    .rd_data(a_rd_data), .rd_last(a_rd_last), .sat(a_sat)
  );

  dc2_toggle_monitor #(.WIDTH(7), .CNT_W(4), .WIN_W(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len),
    .smp_valid(smp_valid), .smp_data(smp_data), .busy(b_busy),
    .rd_valid(b_rd_valid), .rd_ready(rd_ready), .rd_idx(b_rd_idx),
    .rd_data(b_rd_data), .rd_last(b_rd_last), .sat(b_sat)
  );

  int nchk = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- model: phase 0 idle, 1 awaiting first, 2 counting, 3 draining
  int        m_phase = 0;
  int        m_rem = 0;
  int        m_idx = 0;
  logic [6:0] m_prev = '0;
  int        m_cnt[2][8];
  bit        m_sat[2];
  int        m_max[2] = '{65535, 15};

  task automatic m_add(input int k, input int j, input int inc);
    if (inc != 0) begin
      if (m_cnt[k][j] + inc > m_max[k]) begin
        m_cnt[k][j] = m_max[k];
        m_sat[k] = 1'b1;
      end else begin
        m_cnt[k][j] = m_cnt[k][j] + inc;
      end
    end
  endtask

  task automatic model_step();
    logic [6:0] tg;
    if (!rst_n) begin
      m_phase = 0; m_rem = 0; m_idx = 0; m_prev = '0;
      for (int k = 0; k < 2; k++) begin
        m_sat[k] = 1'b0;
        for (int j = 0; j < 8; j++) m_cnt[k][j] = 0;
      end
    end else begin
      case (m_phase)
        0: if (start && win_len != 0) begin
          m_phase = 1; m_rem = int'(win_len);
          for (int k = 0; k < 2; k++) begin
            m_sat[k] = 1'b0;
            for (int j = 0; j < 8; j++) m_cnt[k][j] = 0;
          end
        end
        1, 2: if (smp_valid) begin
          if (m_phase == 2) begin
            tg = m_prev ^ smp_data;
            for (int k = 0; k < 2; k++) begin
              for (int j = 0; j < 7; j++) m_add(k, j, int'(tg[j]));
              m_add(k, 7, $countones(tg));
            end
          end
          m_prev = smp_data;
          m_rem--;
          m_phase = (m_rem == 0) ? 3 : 2;
          m_idx = 0;
        end
        3: if (rd_ready) begin
          if (m_idx == 7) begin m_phase = 0; m_idx = 0; end
          else m_idx++;
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare and drain recording
  int got[2][8];
  int ngot[2];
  logic [7:0] gotmask[2];

  task automatic cmp(input int k, input logic busy, input logic rv,
                     input logic [2:0] idx, input int data,
                     input logic last, input logic st);
    string p;
    p = (k == 0) ? "c16" : "c4";
    chk({p, ".busy"},     int'(busy), int'(m_phase != 0));
    chk({p, ".rd_valid"}, int'(rv),   int'(m_phase == 3));
    chk({p, ".rd_idx"},   int'(idx),  m_idx);
    chk({p, ".rd_data"},  data,       m_cnt[k][m_idx]);
    chk({p, ".rd_last"},  int'(last), int'(m_idx == 7));
    chk({p, ".sat"},      int'(st),   int'(m_sat[k]));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, a_busy, a_rd_valid, a_rd_idx, int'(a_rd_data), a_rd_last, a_sat);
      cmp(1, b_busy, b_rd_valid, b_rd_idx, int'(b_rd_data), b_rd_last, b_sat);
      if (rd_ready && a_rd_valid) begin
        got[0][a_rd_idx] = int'(a_rd_data); ngot[0]++; gotmask[0][a_rd_idx] = 1'b1;
      end
      if (rd_ready && b_rd_valid) begin
        got[1][b_rd_idx] = int'(b_rd_data); ngot[1]++; gotmask[1][b_rd_idx] = 1'b1;
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input int len);
    start = 1'b1;
    win_len = 16'(len);
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [6:0] d);
    smp_valid = 1'b1;
    smp_data = d;
    tick();
    smp_valid = 1'b0;
  endtask

  task automatic clear_rec();
    for (int k = 0; k < 2; k++) begin
      ngot[k] = 0; gotmask[k] = '0;
      for (int j = 0; j < 8; j++) got[k][j] = -1;
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (!a_busy && !b_busy) break;
      tick();
    end
    chk({tag, ".idle_timeout"}, int'(a_busy | b_busy), 0);
  endtask

  task automatic check_res(input string tag, input int k, input int e[8]);
    chk($sformatf("%s.k%0d.ngot", tag, k), ngot[k], 8);
    chk($sformatf("%s.k%0d.mask", tag, k), int'(gotmask[k]), 255);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("%s.k%0d.dut[%0d]", tag, k, j), got[k][j], e[j]);
      chk($sformatf("%s.k%0d.model[%0d]", tag, k, j), m_cnt[k][j], e[j]);
    end
  endtask

  int e16[8];
  int e4[8];

  initial begin
    tick();
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;
    chk("rst.busy", int'(a_busy), 0);
    chk("rst.rd_valid", int'(a_rd_valid), 0);
    chk("rst.rd_idx", int'(a_rd_idx), 0);
    chk("rst.rd_data", int'(a_rd_data), 0);
    chk("rst.sat", int'(b_sat), 0);

    // zero-length start is ignored
    arm(0);
    tick();
    chk("len0.busy", int'(a_busy), 0);

    // T1: basic window
    clear_rec();
    arm(4);
    chk("t1.busy_rise", int'(a_busy), 1);
    send(7'h00); send(7'h7F); send(7'h7F); send(7'h01);
    chk("t1.rd_valid", int'(a_rd_valid), 1);
    wait_idle("t1");
    e16 = '{1, 2, 2, 2, 2, 2, 2, 13};
    check_res("t1", 0, e16);
    check_res("t1", 1, e16);
    chk("t1.sat16", int'(a_sat), 0);

    // T2: single-sample window
    clear_rec();
    arm(1);
    send(7'h55);
    chk("t2.rd_valid_next", int'(a_rd_valid), 1);
    wait_idle("t2");
    e16 = '{0, 0, 0, 0, 0, 0, 0, 0};
    check_res("t2", 0, e16);
    check_res("t2", 1, e16);

    // T3: saturation of the 4-bit instance
    clear_rec();
    arm(20);
    for (int i = 0; i < 20; i++) send((i % 2) ? 7'h01 : 7'h00);
    chk("t3.sat16", int'(a_sat), 0);
    chk("t3.sat4", int'(b_sat), 1);
    wait_idle("t3");
    e16 = '{19, 0, 0, 0, 0, 0, 0, 19};
    e4  = '{15, 0, 0, 0, 0, 0, 0, 15};
    check_res("t3", 0, e16);
    check_res("t3", 1, e4);
    chk("t3.sat4_hold", int'(b_sat), 1);

    // T4: drain back-pressure at index 3
    clear_rec();
    arm(2);
    send(7'h0F); send(7'h03);
    for (int i = 0; i < 20; i++) begin
      if (a_rd_idx == 3'd3) break;
      tick();
    end
    rd_ready = 1'b0;
    chk("t4.reach_idx3", int'(a_rd_idx), 3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4.stall.idx", int'(a_rd_idx), 3);
      chk("t4.stall.data", int'(a_rd_data), 1);
      chk("t4.stall.valid", int'(a_rd_valid), 1);
    end
    rd_ready = 1'b1;
    wait_idle("t4");
    e16 = '{0, 0, 1, 1, 0, 0, 0, 2};
    check_res("t4", 0, e16);
    check_res("t4", 1, e16);

    // T5: gaps and a stray start during COUNT
    clear_rec();
    arm(3);
    send(7'h00);
    tick();
    send(7'h7F);
    start = 1'b1; win_len = 16'd9;
    tick();
    start = 1'b0;
    tick();
    chk("t5.still_counting", int'(a_rd_valid), 0);
    send(7'h01);
    chk("t5.rd_valid", int'(a_rd_valid), 1);
    wait_idle("t5");
    e16 = '{1, 2, 2, 2, 2, 2, 2, 13};
    check_res("t5", 0, e16);
    check_res("t5", 1, e16);

    // T6: reset mid-COUNT, then a fresh window
    clear_rec();
    arm(5);
    send(7'h12); send(7'h34);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6.busy", int'(a_busy), 0);
    chk("t6.rd_valid", int'(a_rd_valid), 0);
    chk("t6.rd_data", int'(a_rd_data), 0);
    chk("t6.busy4", int'(b_busy), 0);
    tick();
    chk("t6.no_drain", ngot[0], 0);
    arm(2);
    send(7'h00); send(7'h03);
    wait_idle("t6");
    e16 = '{1, 1, 0, 0, 0, 0, 0, 2};
    check_res("t6", 0, e16);
    check_res("t6", 1, e16);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
